// File: rtl/pc_gen.sv
// Program counter generator feeding program memory and the fetch register.
// Optional interrupt entry/return support is enabled by defining PCGEN_IRQ_EN.
module pc_gen #(
  parameter int                AWIDTH     = 15,
  parameter int                OWIDTH     = 12,
  parameter logic [AWIDTH-1:0] RESET_ADDR = '0
`ifdef PCGEN_IRQ_EN
  ,
  parameter logic [AWIDTH-1:0] IRQ_VECTOR = AWIDTH'(16'h0010)
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic              redirect_rel,
  input  logic [AWIDTH-1:0] redirect_target,
  input  logic [AWIDTH-1:0] redirect_base,
  input  logic [OWIDTH-1:0] redirect_offset,
  input  logic              halt_req,
  input  logic              resume,
`ifdef PCGEN_IRQ_EN
  input  logic              irq,
  input  logic              irq_ret,
  output logic [AWIDTH-1:0] epc,
  output logic              irq_active,
`endif
  output logic [AWIDTH-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic              halted,
  output logic              wrapped
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [AWIDTH-1:0] pc_next;
  logic              valid_next;
  logic              wrapped_next;
  logic [AWIDTH-1:0] redirect_addr;
  logic [AWIDTH-1:0] rel_target;
  logic              irq_preempt;

  // Offset is sign-extended to the address width; the sum wraps naturally.
  assign rel_target    = redirect_base + AWIDTH'($signed(redirect_offset));
  assign redirect_addr = redirect_rel ? rel_target : redirect_target;

`ifdef PCGEN_IRQ_EN
  logic [AWIDTH-1:0] epc_next;
  logic              irq_active_next;
  logic              irq_ret_take;
  logic              irq_take;

  // An interrupt is only accepted when the pipeline can actually move.
  assign irq_ret_take = irq_ret && irq_active;
  assign irq_take     = irq && !irq_active && !stall;
  assign irq_preempt  = irq_ret_take || irq_take;
`else
  assign irq_preempt  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= BOOT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (!redirect_valid && !irq_preempt && halt_req) state_next = HALT;
      end
      HALT: begin
        if (resume) state_next = RUN;
      end
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    pc_next      = fetch_addr;
    valid_next   = fetch_valid;
    wrapped_next = 1'b0;
`ifdef PCGEN_IRQ_EN
    epc_next        = epc;
    irq_active_next = irq_active;
`endif
    case (state)
      BOOT: valid_next = 1'b1;
      RUN: begin
        valid_next = 1'b1;
        if (redirect_valid) begin
          pc_next = redirect_addr;
`ifdef PCGEN_IRQ_EN
        end else if (irq_ret_take) begin
          pc_next         = epc;
          irq_active_next = 1'b0;
        end else if (irq_take) begin
          epc_next        = fetch_addr;
          pc_next         = IRQ_VECTOR;
          irq_active_next = 1'b1;
`endif
        end else if (halt_req) begin
          valid_next = 1'b0;
        end else if (stall) begin
          valid_next = fetch_valid;
        end else begin
          pc_next      = fetch_addr + 1'b1;
          wrapped_next = &fetch_addr;
        end
      end
      HALT: begin
        valid_next = resume;
        if (redirect_valid) pc_next = redirect_addr;
      end
      default: begin
        pc_next    = RESET_ADDR;
        valid_next = 1'b0;
      end
    endcase
  end

  // All outputs come straight from flops so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_addr  <= RESET_ADDR;
      fetch_valid <= 1'b0;
      wrapped     <= 1'b0;
`ifdef PCGEN_IRQ_EN
      epc         <= '0;
      irq_active  <= 1'b0;
`endif
    end else begin
      fetch_addr  <= pc_next;
      fetch_valid <= valid_next;
      wrapped     <= wrapped_next;
`ifdef PCGEN_IRQ_EN
      epc         <= epc_next;
      irq_active  <= irq_active_next;
`endif
    end
  end

  assign halted = (state == HALT);

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen; observed word is {fetch_addr, fetch_valid, halted, wrapped}.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic        redirect_rel;
  logic [14:0] redirect_target;
  logic [14:0] redirect_base;
  logic [11:0] redirect_offset;
  logic        halt_req;
  logic        resume;
  logic [14:0] fetch_addr;
  logic        fetch_valid;
  logic        halted;
  logic        wrapped;
`ifdef PCGEN_IRQ_EN
  logic        irq;
  logic        irq_ret;
  logic [14:0] epc;
  logic        irq_active;
`endif

  logic [17:0] obs;
  int          checks = 0;
  int          failures = 0;

  assign obs = {fetch_addr, fetch_valid, halted, wrapped};

  always #5 clk = ~clk;

  pc_gen dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_rel    (redirect_rel),
    .redirect_target (redirect_target),
    .redirect_base   (redirect_base),
    .redirect_offset (redirect_offset),
    .halt_req        (halt_req),
    .resume          (resume),
`ifdef PCGEN_IRQ_EN
    .irq             (irq),
    .irq_ret         (irq_ret),
    .epc             (epc),
    .irq_active      (irq_active),
`endif
    .fetch_addr      (fetch_addr),
    .fetch_valid     (fetch_valid),
    .halted          (halted),
    .wrapped         (wrapped)
  );

  // Advance one edge and settle; inputs are changed only after this returns.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_rel    = 1'b0;
    redirect_target = '0;
    redirect_base   = '0;
    redirect_offset = '0;
    halt_req        = 1'b0;
    resume          = 1'b0;
`ifdef PCGEN_IRQ_EN
    irq             = 1'b0;
    irq_ret         = 1'b0;
`endif
  endtask

  task automatic abs_redirect(input logic [14:0] target);
    redirect_valid  = 1'b1;
    redirect_rel    = 1'b0;
    redirect_target = target;
    tick();
    redirect_valid  = 1'b0;
  endtask

  task automatic test_reset();
    logic [14:0] exp_addr [5];
    logic        exp_valid [5];
    exp_addr  = '{15'h0000, 15'h0000, 15'h0001, 15'h0002, 15'h0003};
    exp_valid = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs !== {exp_addr[i], exp_valid[i], 1'b0, 1'b0}) begin
        failures++;
        $display("[TB] FAIL reset_run[%0d] got=%h exp=%h", i, obs, {exp_addr[i], exp_valid[i], 2'b00});
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_stall_redirect();
    abs_redirect(15'h0005);
    checks++;
    if (obs !== {15'h0005, 3'b100}) begin
      failures++;
      $display("[TB] FAIL abs_to_5 got=%h exp=%h", obs, {15'h0005, 3'b100});
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== {15'h0005, 3'b100}) begin
        failures++;
        $display("[TB] FAIL stall_hold[%0d] got=%h exp=%h", i, obs, {15'h0005, 3'b100});
      end
    end
    redirect_valid  = 1'b1;
    redirect_rel    = 1'b1;
    redirect_base   = 15'h0005;
    redirect_offset = 12'hFFD;
    tick();
    clear_inputs();
    checks++;
    if (obs !== {15'h0002, 3'b100}) begin
      failures++;
      $display("[TB] FAIL rel_minus3_over_stall got=%h exp=%h", obs, {15'h0002, 3'b100});
    end
    tick();
    checks++;
    if (obs !== {15'h0003, 3'b100}) begin
      failures++;
      $display("[TB] FAIL inc_after_redirect got=%h exp=%h", obs, {15'h0003, 3'b100});
    end
  endtask

  task automatic test_wrap();
    abs_redirect(15'h7FFE);
    tick();
    checks++;
    if (obs !== {15'h7FFF, 3'b100}) begin
      failures++;
      $display("[TB] FAIL pre_wrap got=%h exp=%h", obs, {15'h7FFF, 3'b100});
    end
    tick();
    checks++;
    if (obs !== {15'h0000, 3'b101}) begin
      failures++;
      $display("[TB] FAIL wrap_pulse got=%h exp=%h", obs, {15'h0000, 3'b101});
    end
    tick();
    checks++;
    if (obs !== {15'h0001, 3'b100}) begin
      failures++;
      $display("[TB] FAIL wrap_one_cycle got=%h exp=%h", obs, {15'h0001, 3'b100});
    end
    abs_redirect(15'h7FFF);
    abs_redirect(15'h0000);
    checks++;
    if (obs !== {15'h0000, 3'b100}) begin
      failures++;
      $display("[TB] FAIL redirect_to_0_no_wrap got=%h exp=%h", obs, {15'h0000, 3'b100});
    end
    // Relative targets that cross the top and bottom of the address space.
    redirect_valid  = 1'b1;
    redirect_rel    = 1'b1;
    redirect_base   = 15'h7FFE;
    redirect_offset = 12'h005;
    tick();
    checks++;
    if (obs !== {15'h0003, 3'b100}) begin
      failures++;
      $display("[TB] FAIL rel_plus5_wrap got=%h exp=%h", obs, {15'h0003, 3'b100});
    end
    redirect_base   = 15'h0100;
    redirect_offset = 12'h800;
    tick();
    clear_inputs();
    checks++;
    if (obs !== {15'h7900, 3'b100}) begin
      failures++;
      $display("[TB] FAIL rel_min_offset got=%h exp=%h", obs, {15'h7900, 3'b100});
    end
  endtask

  task automatic test_halt();
    abs_redirect(15'h0020);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    checks++;
    if (obs !== {15'h0020, 3'b010}) begin
      failures++;
      $display("[TB] FAIL halt_enter got=%h exp=%h", obs, {15'h0020, 3'b010});
    end
    stall = 1'b1;
    tick();
    checks++;
    if (obs !== {15'h0020, 3'b010}) begin
      failures++;
      $display("[TB] FAIL halt_hold got=%h exp=%h", obs, {15'h0020, 3'b010});
    end
    stall = 1'b0;
    abs_redirect(15'h0100);
    checks++;
    if (obs !== {15'h0100, 3'b010}) begin
      failures++;
      $display("[TB] FAIL halt_redirect got=%h exp=%h", obs, {15'h0100, 3'b010});
    end
    resume   = 1'b1;
    halt_req = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if (obs !== {15'h0100, 3'b100}) begin
      failures++;
      $display("[TB] FAIL resume_wins got=%h exp=%h", obs, {15'h0100, 3'b100});
    end
    tick();
    checks++;
    if (obs !== {15'h0101, 3'b100}) begin
      failures++;
      $display("[TB] FAIL resume_inc got=%h exp=%h", obs, {15'h0101, 3'b100});
    end
  endtask

  task automatic test_priority();
    halt_req        = 1'b1;
    stall           = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 15'h0200;
    tick();
    clear_inputs();
    checks++;
    if (obs !== {15'h0200, 3'b100}) begin
      failures++;
      $display("[TB] FAIL redirect_beats_halt got=%h exp=%h", obs, {15'h0200, 3'b100});
    end
    halt_req = 1'b1;
    stall    = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if (obs !== {15'h0200, 3'b010}) begin
      failures++;
      $display("[TB] FAIL halt_beats_stall got=%h exp=%h", obs, {15'h0200, 3'b010});
    end
  endtask

  task automatic test_reset_in_halt();
    rst             = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 15'h0333;
    tick();
    clear_inputs();
    rst = 1'b0;
    checks++;
    if (obs !== {15'h0000, 3'b000}) begin
      failures++;
      $display("[TB] FAIL reset_from_halt got=%h exp=%h", obs, {15'h0000, 3'b000});
    end
    tick();
    checks++;
    if (obs !== {15'h0000, 3'b100}) begin
      failures++;
      $display("[TB] FAIL boot_after_reset got=%h exp=%h", obs, {15'h0000, 3'b100});
    end
    tick();
    checks++;
    if (obs !== {15'h0001, 3'b100}) begin
      failures++;
      $display("[TB] FAIL run_after_reset got=%h exp=%h", obs, {15'h0001, 3'b100});
    end
  endtask

`ifdef PCGEN_IRQ_EN
  task automatic test_irq();
    abs_redirect(15'h0040);
    irq = 1'b1;
    tick();
    checks++;
    if ({obs, epc, irq_active} !== {15'h0010, 3'b100, 15'h0040, 1'b1}) begin
      failures++;
      $display("[TB] FAIL irq_entry got=%h exp=%h", {obs, epc, irq_active}, {15'h0010, 3'b100, 15'h0040, 1'b1});
    end
    tick();
    irq = 1'b0;
    checks++;
    if ({obs, epc, irq_active} !== {15'h0011, 3'b100, 15'h0040, 1'b1}) begin
      failures++;
      $display("[TB] FAIL irq_masked got=%h exp=%h", {obs, epc, irq_active}, {15'h0011, 3'b100, 15'h0040, 1'b1});
    end
    irq_ret = 1'b1;
    tick();
    checks++;
    if ({obs, irq_active} !== {15'h0040, 3'b100, 1'b0}) begin
      failures++;
      $display("[TB] FAIL irq_return got=%h exp=%h", {obs, irq_active}, {15'h0040, 3'b100, 1'b0});
    end
    tick();
    irq_ret = 1'b0;
    checks++;
    if ({obs, irq_active} !== {15'h0041, 3'b100, 1'b0}) begin
      failures++;
      $display("[TB] FAIL irq_ret_ignored got=%h exp=%h", {obs, irq_active}, {15'h0041, 3'b100, 1'b0});
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_stall_redirect();
    test_wrap();
    test_halt();
    test_priority();
    test_reset_in_halt();
`ifdef PCGEN_IRQ_EN
    test_irq();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
